mem_arbiter: RTL and testbench

Two-requester arbiter sequencing the single-port 256x16 RISC machine data/instruction RAM. Port 0 serves the CPU and port 1 serves a loader/debug master, such as a program loader that fills RAM before release. The block sits between both masters and the RAM. It grants one access at a time with round-robin fairness, drives the RAM address/write strobe, and returns read data with a one-cycle acknowledge.

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a single-port synchronous RAM.
// Each access takes IDLE -> ACCESS -> RESP, and a registered ack is raised on return to IDLE.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                ack0_q, ack1_q;
    logic [DATA_W-1:0]   rdata0_q, rdata1_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                we_q;
    logic                ram_we_q;
    logic                owner_q;
    logic                last_grant_q;
    logic                elig0_s, elig1_s, grant_s, win_s;

    // Eligibility masks a port whose ack is high, so a stale req is never re-served.
    always_comb begin
        elig0_s = req0 & ~ack0_q;
        elig1_s = req1 & ~ack1_q;
        grant_s = elig0_s | elig1_s;
        if (elig0_s && elig1_s) begin
            win_s = ~last_grant_q;
        end else if (elig1_s) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = grant_s ? ACCESS : IDLE;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Request latch, RAM strobe, acknowledge and read-data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            ram_we_q     <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            ram_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_s) begin
                        owner_q      <= win_s;
                        last_grant_q <= win_s;
                        we_q         <= win_s ? we1 : we0;
                        ram_we_q     <= win_s ? we1 : we0;
                        addr_q       <= win_s ? addr1 : addr0;
                        wdata_q      <= win_s ? wdata1 : wdata0;
                    end else begin
                        owner_q <= owner_q;
                    end
                end
                ACCESS: begin
                    ram_we_q <= 1'b0;
                end
                RESP: begin
                    if (owner_q) begin
                        ack1_q <= 1'b1;
                        if (!we_q) begin
                            rdata1_q <= ram_rdata;
                        end else begin
                            rdata1_q <= rdata1_q;
                        end
                    end else begin
                        ack0_q <= 1'b1;
                        if (!we_q) begin
                            rdata0_q <= ram_rdata;
                        end else begin
                            rdata0_q <= rdata0_q;
                        end
                    end
                end
                default: begin
                    ram_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_we    = ram_we_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cycle-accurate hand sequences plus a transaction table,
// with acks scored against a queue of expected completions and a behavioural RAM.
module tb_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req0, req1, we0, we1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        busy, owner;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        port;
        logic        we;
        logic [15:0] rd;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        port;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

    logic [15:0] mem [256];
    logic [15:0] exp_rd [2];

    mem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous RAM.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every ack pops the next expected completion.
    always @(negedge clk) begin
        if (reset_n && (ack0 || ack1)) begin
            chk("ack_onehot", {31'd0, ack0 & ack1}, 32'd0);
            if (sb_q.size() == 0) begin
                chk("ack_unexpected", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("ack_port", {31'd0, ack1}, {31'd0, e.port});
                if (!e.we) exp_rd[e.port] = e.rd;
                chk("rdata0", {16'd0, rdata0}, {16'd0, exp_rd[0]});
                chk("rdata1", {16'd0, rdata1}, {16'd0, exp_rd[1]});
            end
        end
    end

    task automatic drv(input logic p, input logic r, input logic w,
                       input logic [7:0] a, input logic [15:0] d);
        if (p) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic push(input logic p, input logic w, input logic [15:0] rd);
        sb_t e;
        e.port = p; e.we = w; e.rd = rd;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        drv(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        sb_q.delete();
        exp_rd[0] = 16'h0000;
        exp_rd[1] = 16'h0000;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [7];
        int   lat;
        tv[0] = '{1'b0, 1'b1, 8'h00, 16'h0001, 16'h0000};
        tv[1] = '{1'b1, 1'b1, 8'hFF, 16'hBEEF, 16'h0000};
        tv[2] = '{1'b0, 1'b0, 8'hFF, 16'h0000, 16'hBEEF};
        tv[3] = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'h0001};
        tv[4] = '{1'b1, 1'b1, 8'h80, 16'h5A5A, 16'h0000};
        tv[5] = '{1'b1, 1'b0, 8'h80, 16'h0000, 16'h5A5A};
        tv[6] = '{1'b0, 1'b0, 8'h00, 16'h0000, 16'h0001};

        reset_n = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        drv(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        exp_rd[0] = 16'h0000;
        exp_rd[1] = 16'h0000;
        #12;
        chk("rst_ack0", {31'd0, ack0}, 32'd0);
        chk("rst_ack1", {31'd0, ack1}, 32'd0);
        chk("rst_rdata", {rdata1, rdata0}, 32'd0);
        chk("rst_ram", {7'd0, ram_we, ram_addr, ram_wdata}, 32'd0);
        chk("rst_busy_owner", {30'd0, busy, owner}, 32'd0);
        do_reset();

        // Port 0 write 0x1234 to 0x19.
        @(negedge clk);
        drv(1'b0, 1'b1, 1'b1, 8'h19, 16'h1234);
        push(1'b0, 1'b1, 16'h0000);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("t1_ram_we", {31'd0, ram_we}, {31'd0, c == 1});
            chk("t1_ack0", {31'd0, ack0}, {31'd0, c == 3});
            chk("t1_ack1", {31'd0, ack1}, 32'd0);
            if (c == 1) chk("t1_ram_addr", {24'd0, ram_addr}, 32'h19);
            if (c == 3) drv(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        end

        // Port 1 reads it back.
        drv(1'b1, 1'b1, 1'b0, 8'h19, 16'h0000);
        push(1'b1, 1'b0, 16'h1234);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("t2_ack1", {31'd0, ack1}, {31'd0, c == 3});
            if (c == 3) begin
                chk("t2_rdata1", {16'd0, rdata1}, 32'h1234);
                chk("t2_rdata0", {16'd0, rdata0}, 32'h0000);
                drv(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
            end
        end

        // Simultaneous requests after reset: port 0 wins the tie.
        do_reset();
        @(negedge clk);
        drv(1'b0, 1'b1, 1'b1, 8'h30, 16'hABCD);
        drv(1'b1, 1'b1, 1'b0, 8'h30, 16'h0000);
        push(1'b0, 1'b1, 16'h0000);
        push(1'b1, 1'b0, 16'hABCD);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk("t3_ack0", {31'd0, ack0}, {31'd0, c == 3});
            chk("t3_ack1", {31'd0, ack1}, {31'd0, c == 6});
            if (c == 1) chk("t3_access0", {30'd0, owner, ram_we}, 32'd1);
            if (c == 4) chk("t3_access1", {29'd0, busy, owner, ram_we}, 32'd6);
            if (c == 3) drv(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
            if (c == 6) drv(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        end

        // Continuous contention: grants alternate 0,1,0,1.
        do_reset();
        @(negedge clk);
        drv(1'b0, 1'b1, 1'b1, 8'h40, 16'h4000);
        drv(1'b1, 1'b1, 1'b1, 8'h41, 16'h4100);
        for (int k = 0; k < 4; k++) push(k[0], 1'b1, 16'h0000);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            chk("t4_ack0", {31'd0, ack0}, {31'd0, c == 3 || c == 9});
            chk("t4_ack1", {31'd0, ack1}, {31'd0, c == 6 || c == 12});
            chk("t4_ram_we", {31'd0, ram_we}, {31'd0, c == 1 || c == 4 || c == 7 || c == 10});
            if (c == 1 || c == 7) chk("t4_owner0", {31'd0, owner}, 32'd0);
            if (c == 4 || c == 10) chk("t4_owner1", {31'd0, owner}, 32'd1);
            if (c == 12) begin
                drv(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
                drv(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
            end
        end
        chk("t4_mem40", {16'd0, mem[8'h40]}, 32'h4000);
        chk("t4_mem41", {16'd0, mem[8'h41]}, 32'h4100);

        // Stale req held through the ack cycle is not re-served.
        do_reset();
        @(negedge clk);
        drv(1'b0, 1'b1, 1'b1, 8'h50, 16'h0550);
        push(1'b0, 1'b1, 16'h0000);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("t5_ram_we", {31'd0, ram_we}, {31'd0, c == 1});
            chk("t5_ack0", {31'd0, ack0}, {31'd0, c == 3});
            if (c == 4) drv(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        end
        chk("t5_sb_empty", sb_q.size(), 32'd0);

        // Reset in the ACCESS cycle of a write.
        do_reset();
        @(negedge clk);
        drv(1'b0, 1'b1, 1'b1, 8'd25, 16'hFFE9);
        @(negedge clk);
        chk("t6_access", {30'd0, busy, ram_we}, 32'd3);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_now", {29'd0, ram_we, busy, ack0}, 32'd0);
        drv(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t6_after", {28'd0, busy, owner, ack0, ack1}, 32'd0);
        end

        // Table of single transactions, latency checked per entry.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drv(tv[i].port, 1'b1, tv[i].we, tv[i].addr, tv[i].wdata);
            push(tv[i].port, tv[i].we, tv[i].exp_rd);
            lat = 0;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if ((tv[i].port ? ack1 : ack0) == 1'b1) begin
                    lat = k;
                    break;
                end
            end
            chk($sformatf("vec%0d_latency", i), lat, 32'd3);
            drv(tv[i].port, 1'b0, 1'b0, 8'h00, 16'h0000);
        end
        repeat (3) @(negedge clk);
        chk("tbl_sb_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
